// File: rtl/keypad_entry_controller_if.sv
// Keypad entry bundle: encoder side, front-panel controls and the load
// handshake toward the cook timer. slave = controller, master = its environment.
interface keypad_entry_controller_if;
  logic        entry_en;
  logic [3:0]  enc_code;
  logic        zero_key;
  logic        clear;
  logic        start;
  logic        load_ready;
  logic        enc_enable;
  logic [15:0] time_bcd;
  logic [2:0]  digit_count;
  logic        digit_strobe;
  logic        load_valid;
  logic        entry_err;

  modport slave (
    input  entry_en, enc_code, zero_key, clear, start, load_ready,
    output enc_enable, time_bcd, digit_count, digit_strobe, load_valid, entry_err
  );

  modport master (
    output entry_en, enc_code, zero_key, clear, start, load_ready,
    input  enc_enable, time_bcd, digit_count, digit_strobe, load_valid, entry_err
  );
endinterface

// File: rtl/keypad_entry_controller.sv
// Microwave keypad time-entry sequencer: debounces keys, builds a 4-digit MM:SS
// BCD buffer and hands it to the cook timer. Optional idle auto-clear: KEYPAD_TIMEOUT_EN.
module keypad_entry_controller #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic                       clk,
  input logic                       reset,
  keypad_entry_controller_if.slave  kp
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    PRESS,
    RELEASE,
    LOAD
  } state_t;

  localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);

  state_t      state;
  logic [3:0]  digit_latched;
  logic [3:0]  stab_cnt;
  logic        enc_enable;
  logic [15:0] time_bcd;
  logic [2:0]  digit_count;
  logic        digit_strobe;
  logic        load_valid;
  logic        entry_err;

  logic        key_present;
  logic        start_ok;
  logic        timeout_hit;

  // The encoder cannot report digit 0, so zero_key stands in for it; a nonzero code wins.
  assign key_present = (kp.enc_code != 4'd0) | kp.zero_key;
  assign start_ok    = (digit_count != 3'd0) && (time_bcd[7:4] <= 4'd5);

  assign kp.enc_enable   = enc_enable;
  assign kp.time_bcd     = time_bcd;
  assign kp.digit_count  = digit_count;
  assign kp.digit_strobe = digit_strobe;
  assign kp.load_valid   = load_valid;
  assign kp.entry_err    = entry_err;

`ifdef KEYPAD_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              entry_active;

  assign entry_active = (state == SCAN) || (state == PRESS) || (state == RELEASE);
  assign timeout_hit  = entry_active && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (!entry_active || (digit_count == 3'd0) || key_present || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  // Auto-clear is compiled out; the buffer is kept until clear, load or entry_en drop.
  assign timeout_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      digit_latched <= 4'd0;
      stab_cnt      <= 4'd0;
      enc_enable    <= 1'b0;
      time_bcd      <= 16'h0000;
      digit_count   <= 3'd0;
      digit_strobe  <= 1'b0;
      load_valid    <= 1'b0;
      entry_err     <= 1'b0;
    end else begin
      digit_strobe <= 1'b0;
      entry_err    <= 1'b0;
      case (state)
        IDLE: begin
          stab_cnt <= 4'd0;
          if (kp.clear) begin
            time_bcd    <= 16'h0000;
            digit_count <= 3'd0;
          end
          if (kp.entry_en) begin
            state      <= SCAN;
            enc_enable <= 1'b1;
          end
        end

        LOAD: begin
          if (load_valid && kp.load_ready) begin
            time_bcd    <= 16'h0000;
            digit_count <= 3'd0;
            load_valid  <= 1'b0;
            state       <= kp.entry_en ? SCAN : IDLE;
            enc_enable  <= kp.entry_en;
          end
        end

        // SCAN / PRESS / RELEASE: global overrides first, then the debounce machine.
        default: begin
          if (!kp.entry_en) begin
            state       <= IDLE;
            enc_enable  <= 1'b0;
            stab_cnt    <= 4'd0;
            time_bcd    <= 16'h0000;
            digit_count <= 3'd0;
          end else if (kp.clear || timeout_hit) begin
            state       <= SCAN;
            stab_cnt    <= 4'd0;
            time_bcd    <= 16'h0000;
            digit_count <= 3'd0;
          end else if (kp.start) begin
            if (start_ok) begin
              state      <= LOAD;
              enc_enable <= 1'b0;
              load_valid <= 1'b1;
              stab_cnt   <= 4'd0;
            end else begin
              entry_err <= 1'b1;
            end
          end else begin
            case (state)
              SCAN: begin
                if (key_present) begin
                  digit_latched <= kp.enc_code;
                  stab_cnt      <= 4'd1;
                  state         <= PRESS;
                end
              end
              PRESS: begin
                if (key_present && (kp.enc_code == digit_latched)) begin
                  if (stab_cnt >= STABLE_LAST) begin
                    stab_cnt <= 4'd0;
                    state    <= RELEASE;
                    if (digit_count < 3'd4) begin
                      time_bcd     <= {time_bcd[11:0], digit_latched};
                      digit_count  <= digit_count + 3'd1;
                      digit_strobe <= 1'b1;
                    end
                  end else begin
                    stab_cnt <= stab_cnt + 4'd1;
                  end
                end else begin
                  stab_cnt <= 4'd0;
                  state    <= SCAN;
                end
              end
              RELEASE: begin
                if (key_present) begin
                  stab_cnt <= 4'd0;
                end else if (stab_cnt >= STABLE_LAST) begin
                  stab_cnt <= 4'd0;
                  state    <= SCAN;
                end else begin
                  stab_cnt <= stab_cnt + 4'd1;
                end
              end
              default: begin
                state      <= IDLE;
                enc_enable <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Scoreboard bench for keypad_entry_controller: stimulus pushes expected strobe/err/load
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_keypad_entry_controller;

  localparam int STABLE = 4;
  localparam int EV_STROBE = 0;
  localparam int EV_ERR = 1;
  localparam int EV_LOAD = 2;

  typedef struct {
    int          kind;
    logic [15:0] bcd;
    logic [2:0]  cnt;
    int          cyc;
  } evt_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  evt_t sb[$];

  keypad_entry_controller_if kif ();

  keypad_entry_controller #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_evt(input int kind, input logic [15:0] bcd, input logic [2:0] cnt, input int c);
    evt_t e;
    e.kind = kind;
    e.bcd  = bcd;
    e.cnt  = cnt;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Hold a key for `hold` cycles then release for `gap`; optionally expect one accepted digit.
  task automatic apply_stimulus(input logic [3:0] code, input logic zk, input int hold, input int gap,
                                input bit expect_strobe, input logic [15:0] bcd, input logic [2:0] cnt);
    kif.enc_code = code;
    kif.zero_key = zk;
    if (expect_strobe) push_evt(EV_STROBE, bcd, cnt, cyc + STABLE);
    tick(hold);
    kif.enc_code = 4'd0;
    kif.zero_key = 1'b0;
    tick(gap);
  endtask

  task automatic mon_event(input int kind, input string name);
    evt_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_%s actual=present required=none (cycle %0d)", name, cyc);
    end else begin
      e = sb.pop_front();
      check_output({name, "_kind"}, kind, e.kind);
      if (kind == EV_STROBE || kind == EV_LOAD) begin
        check_output({name, "_bcd"}, kif.time_bcd, e.bcd);
        check_output({name, "_count"}, kif.digit_count, e.cnt);
      end
      if (e.cyc >= 0) check_output({name, "_cycle"}, cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (kif.digit_strobe) mon_event(EV_STROBE, "strobe");
      if (kif.entry_err) mon_event(EV_ERR, "err");
      if (kif.load_valid && kif.load_ready) mon_event(EV_LOAD, "load");
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    reset = 1'b1;
    kif.entry_en = 1'b0;
    kif.enc_code = 4'd0;
    kif.zero_key = 1'b0;
    kif.clear = 1'b0;
    kif.start = 1'b0;
    kif.load_ready = 1'b0;
    tick(3);
    check_output("rst_enc_enable", kif.enc_enable, 0);
    check_output("rst_time_bcd", kif.time_bcd, 0);
    check_output("rst_digit_count", kif.digit_count, 0);
    check_output("rst_load_valid", kif.load_valid, 0);
    check_output("rst_strobe", kif.digit_strobe, 0);
    check_output("rst_err", kif.entry_err, 0);
    reset = 1'b0;
    tick(2);
    check_output("idle_enc_enable", kif.enc_enable, 0);
    kif.entry_en = 1'b1;
    tick(1);
    check_output("scan_enc_enable", kif.enc_enable, 1);

    // 1, zero_key, 3 -> 0103
    apply_stimulus(4'd1, 1'b0, 4, 4, 1'b1, 16'h0001, 3'd1);
    apply_stimulus(4'd0, 1'b1, 4, 4, 1'b1, 16'h0010, 3'd2);
    apply_stimulus(4'd3, 1'b0, 4, 4, 1'b1, 16'h0103, 3'd3);
    check_output("bcd_0103", kif.time_bcd, 16'h0103);
    check_output("count_3", kif.digit_count, 3);

    // Short bounce: not accepted
    apply_stimulus(4'd7, 1'b0, 3, 4, 1'b0, 16'h0, 3'd0);
    check_output("bounce_bcd", kif.time_bcd, 16'h0103);
    check_output("bounce_count", kif.digit_count, 3);

    kif.clear = 1'b1;
    tick(1);
    kif.clear = 1'b0;
    check_output("clear_bcd", kif.time_bcd, 0);
    check_output("clear_count", kif.digit_count, 0);

    // Five digits: fifth is dropped without a strobe
    apply_stimulus(4'd1, 1'b0, 4, 4, 1'b1, 16'h0001, 3'd1);
    apply_stimulus(4'd2, 1'b0, 4, 4, 1'b1, 16'h0012, 3'd2);
    apply_stimulus(4'd3, 1'b0, 4, 4, 1'b1, 16'h0123, 3'd3);
    apply_stimulus(4'd4, 1'b0, 4, 4, 1'b1, 16'h1234, 3'd4);
    apply_stimulus(4'd5, 1'b0, 4, 4, 1'b0, 16'h0, 3'd0);
    check_output("full_bcd", kif.time_bcd, 16'h1234);
    check_output("full_count", kif.digit_count, 4);

    kif.clear = 1'b1;
    tick(1);
    kif.clear = 1'b0;

    // 01:30 load with a stalled timer
    apply_stimulus(4'd1, 1'b0, 4, 4, 1'b1, 16'h0001, 3'd1);
    apply_stimulus(4'd3, 1'b0, 4, 4, 1'b1, 16'h0013, 3'd2);
    apply_stimulus(4'd0, 1'b1, 4, 4, 1'b1, 16'h0130, 3'd3);
    kif.start = 1'b1;
    push_evt(EV_LOAD, 16'h0130, 3'd3, -1);
    tick(1);
    kif.start = 1'b0;
    check_output("load_valid_up", kif.load_valid, 1);
    check_output("load_enc_off", kif.enc_enable, 0);
    for (int i = 0; i < 5; i++) begin
      kif.enc_code = 4'd9;
      kif.start = (i == 1);
      kif.clear = (i == 2);
      tick(1);
      check_output("load_hold_bcd", kif.time_bcd, 16'h0130);
      check_output("load_hold_valid", kif.load_valid, 1);
    end
    kif.enc_code = 4'd0;
    kif.start = 1'b0;
    kif.clear = 1'b0;
    kif.load_ready = 1'b1;
    tick(1);
    kif.load_ready = 1'b0;
    check_output("post_load_bcd", kif.time_bcd, 0);
    check_output("post_load_count", kif.digit_count, 0);
    check_output("post_load_valid", kif.load_valid, 0);
    check_output("post_load_scan", kif.enc_enable, 1);

    // 00:90 is not a valid time
    apply_stimulus(4'd9, 1'b0, 4, 4, 1'b1, 16'h0009, 3'd1);
    apply_stimulus(4'd0, 1'b1, 4, 4, 1'b1, 16'h0090, 3'd2);
    kif.start = 1'b1;
    push_evt(EV_ERR, 16'h0, 3'd0, cyc + 1);
    tick(1);
    kif.start = 1'b0;
    check_output("err_no_valid", kif.load_valid, 0);
    check_output("err_bcd_kept", kif.time_bcd, 16'h0090);
    check_output("err_count_kept", kif.digit_count, 2);
    kif.clear = 1'b1;
    kif.start = 1'b1;
    tick(1);
    kif.clear = 1'b0;
    kif.start = 1'b0;
    check_output("clr_start_bcd", kif.time_bcd, 0);
    check_output("clr_start_valid", kif.load_valid, 0);
    kif.start = 1'b1;
    push_evt(EV_ERR, 16'h0, 3'd0, cyc + 1);
    tick(1);
    kif.start = 1'b0;
    check_output("empty_start_valid", kif.load_valid, 0);

    // 00:59 boundary accepted, ready already high
    apply_stimulus(4'd5, 1'b0, 4, 4, 1'b1, 16'h0005, 3'd1);
    apply_stimulus(4'd9, 1'b0, 4, 4, 1'b1, 16'h0059, 3'd2);
    kif.start = 1'b1;
    kif.load_ready = 1'b1;
    push_evt(EV_LOAD, 16'h0059, 3'd2, -1);
    tick(1);
    kif.start = 1'b0;
    check_output("b59_valid", kif.load_valid, 1);
    tick(1);
    kif.load_ready = 1'b0;
    check_output("b59_bcd", kif.time_bcd, 0);
    check_output("b59_valid_low", kif.load_valid, 0);

    // Idle retention / auto-clear
    apply_stimulus(4'd2, 1'b0, 4, 4, 1'b1, 16'h0002, 3'd1);
    tick(30);
`ifdef KEYPAD_TIMEOUT_EN
    check_output("idle_bcd", kif.time_bcd, 0);
    check_output("idle_count", kif.digit_count, 0);
`else
    check_output("idle_bcd", kif.time_bcd, 16'h0002);
    check_output("idle_count", kif.digit_count, 1);
`endif

    kif.entry_en = 1'b0;
    tick(1);
    check_output("dis_enc_off", kif.enc_enable, 0);
    check_output("dis_bcd", kif.time_bcd, 0);
    check_output("dis_count", kif.digit_count, 0);
    kif.entry_en = 1'b1;
    tick(1);
    check_output("reen_enc_on", kif.enc_enable, 1);

    // Reset in the middle of a load
    apply_stimulus(4'd4, 1'b0, 4, 4, 1'b1, 16'h0004, 3'd1);
    kif.start = 1'b1;
    tick(1);
    kif.start = 1'b0;
    check_output("pre_rst_valid", kif.load_valid, 1);
    #3;
    reset = 1'b1;
    #1;
    check_output("midrst_valid", kif.load_valid, 0);
    check_output("midrst_enc", kif.enc_enable, 0);
    check_output("midrst_bcd", kif.time_bcd, 0);
    check_output("midrst_count", kif.digit_count, 0);
    kif.entry_en = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    check_output("post_rst_idle", kif.enc_enable, 0);
    check_output("post_rst_valid", kif.load_valid, 0);
    kif.entry_en = 1'b1;
    tick(1);
    check_output("post_rst_scan", kif.enc_enable, 1);

    tick(3);
    check_output("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
